// File: rtl/core_pkg.sv
// Shared constants and types for the MIPS32 core: datapath widths, instruction
// field positions and the ID/EX pipeline bundle.
package core_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [DATA_W-1:0] NOP = 32'h0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [IDX_W-1:0]  rs_idx;
        logic [IDX_W-1:0]  rt_idx;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
    } idex_bundle_t;

endpackage

// File: rtl/id_operand_sel.sv
// One ID operand path: write-back forward mux for the incoming operand, and the
// snoop that refreshes an operand already held in ID/EX while the stage is stalled.
module id_operand_sel #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic [DATA_W-1:0] rf_data,
    input  logic              fwd,
    input  logic              wb_regwr,
    input  logic [IDX_W-1:0]  wb_rd_idx,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              held_valid,
    input  logic [IDX_W-1:0]  held_idx,
    input  logic [DATA_W-1:0] held_data,
    output logic [DATA_W-1:0] sel_data,
    output logic [DATA_W-1:0] held_next
);

    logic snoop_hit;

    always_comb begin
        sel_data  = fwd ? wb_wdata : rf_data;
        // $0 is hard-wired to zero, so a write-back aimed at it must never leak in.
        snoop_hit = held_valid && wb_regwr && (wb_rd_idx != '0) && (wb_rd_idx == held_idx);
        held_next = snoop_hit ? wb_wdata : held_data;
    end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage operand select and ID/EX pipeline register, with stall hold,
// flush-to-bubble and stall-time write-back snooping of the held operands.
module id_operand_stage #(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int IDX_W  = core_pkg::IDX_W,
    parameter int CNT_W  = 16
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_IFID_valid,
    input  logic [DATA_W-1:0] in_IFID_pc,
    input  logic [DATA_W-1:0] in_IFID_instr,
    output logic [IDX_W-1:0]  out_IFID_rs_idx,
    output logic [IDX_W-1:0]  out_IFID_rt_idx,
    input  logic [DATA_W-1:0] in_rf_rs_data,
    input  logic [DATA_W-1:0] in_rf_rt_data,
    input  logic              in_Mem_forwardA,
    input  logic              in_Mem_forwardB,
    input  logic              in_MEMWB_RegWr,
    input  logic [IDX_W-1:0]  in_MEMWB_rd_idx,
    input  logic [DATA_W-1:0] in_MEMWB_wdata,
    input  logic              in_stall,
    input  logic              in_flush,
    output logic              out_IDEX_valid,
    output logic [DATA_W-1:0] out_IDEX_pc,
    output logic [DATA_W-1:0] out_IDEX_instr,
    output logic [IDX_W-1:0]  out_IDEX_rs_idx,
    output logic [IDX_W-1:0]  out_IDEX_rt_idx,
    output logic [DATA_W-1:0] out_IDEX_rs_data,
    output logic [DATA_W-1:0] out_IDEX_rt_data,
    output logic [CNT_W-1:0]  out_stall_cnt
);

    import core_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    idex_bundle_t      idex_d, idex_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic [DATA_W-1:0] rs_sel, rt_sel, rs_held_next, rt_held_next;

    assign out_IFID_rs_idx = in_IFID_instr[RS_MSB:RS_LSB];
    assign out_IFID_rt_idx = in_IFID_instr[RT_MSB:RT_LSB];

    id_operand_sel #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rs_sel (
        .rf_data    (in_rf_rs_data),
        .fwd        (in_Mem_forwardA),
        .wb_regwr   (in_MEMWB_RegWr),
        .wb_rd_idx  (in_MEMWB_rd_idx),
        .wb_wdata   (in_MEMWB_wdata),
        .held_valid (idex_q.valid),
        .held_idx   (idex_q.rs_idx),
        .held_data  (idex_q.rs_data),
        .sel_data   (rs_sel),
        .held_next  (rs_held_next)
    );

    id_operand_sel #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rt_sel (
        .rf_data    (in_rf_rt_data),
        .fwd        (in_Mem_forwardB),
        .wb_regwr   (in_MEMWB_RegWr),
        .wb_rd_idx  (in_MEMWB_rd_idx),
        .wb_wdata   (in_MEMWB_wdata),
        .held_valid (idex_q.valid),
        .held_idx   (idex_q.rt_idx),
        .held_data  (idex_q.rt_data),
        .sel_data   (rt_sel),
        .held_next  (rt_held_next)
    );

    always_comb begin
        // NOTE: defaulting every comb output to its held value first means no path can infer a latch.
        idex_d      = idex_q;
        stall_cnt_d = stall_cnt_q;

        if (in_flush) begin
            idex_d.valid = 1'b0;
            idex_d.instr = NOP;
        end else if (in_stall) begin
            idex_d.rs_data = rs_held_next;
            idex_d.rt_data = rt_held_next;
        end else begin
            idex_d.valid   = in_IFID_valid;
            idex_d.pc      = in_IFID_pc;
            idex_d.instr   = in_IFID_instr;
            idex_d.rs_idx  = out_IFID_rs_idx;
            idex_d.rt_idx  = out_IFID_rt_idx;
            idex_d.rs_data = rs_sel;
            idex_d.rt_data = rt_sel;
        end

        // Only stalls that hold a real instruction are counted; a flush edge is not.
        if (in_stall && idex_q.valid && !in_flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            idex_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_IDEX_valid   = idex_q.valid;
    assign out_IDEX_pc      = idex_q.pc;
    assign out_IDEX_instr   = idex_q.instr;
    assign out_IDEX_rs_idx  = idex_q.rs_idx;
    assign out_IDEX_rt_idx  = idex_q.rt_idx;
    assign out_IDEX_rs_data = idex_q.rs_data;
    assign out_IDEX_rt_data = idex_q.rt_data;
    assign out_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the ID/EX register.
module tb_id_operand_stage;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_IFID_valid;
    logic [31:0] in_IFID_pc, in_IFID_instr;
    logic [4:0]  out_IFID_rs_idx, out_IFID_rt_idx;
    logic [31:0] in_rf_rs_data, in_rf_rt_data;
    logic        in_Mem_forwardA, in_Mem_forwardB;
    logic        in_MEMWB_RegWr;
    logic [4:0]  in_MEMWB_rd_idx;
    logic [31:0] in_MEMWB_wdata;
    logic        in_stall, in_flush;
    logic        out_IDEX_valid;
    logic [31:0] out_IDEX_pc, out_IDEX_instr;
    logic [4:0]  out_IDEX_rs_idx, out_IDEX_rt_idx;
    logic [31:0] out_IDEX_rs_data, out_IDEX_rt_data;
    logic [15:0] out_stall_cnt;

    int checks = 0;
    int errors = 0;

    id_operand_stage dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_IFID_valid(in_IFID_valid), .in_IFID_pc(in_IFID_pc), .in_IFID_instr(in_IFID_instr),
        .out_IFID_rs_idx(out_IFID_rs_idx), .out_IFID_rt_idx(out_IFID_rt_idx),
        .in_rf_rs_data(in_rf_rs_data), .in_rf_rt_data(in_rf_rt_data),
        .in_Mem_forwardA(in_Mem_forwardA), .in_Mem_forwardB(in_Mem_forwardB),
        .in_MEMWB_RegWr(in_MEMWB_RegWr), .in_MEMWB_rd_idx(in_MEMWB_rd_idx),
        .in_MEMWB_wdata(in_MEMWB_wdata), .in_stall(in_stall), .in_flush(in_flush),
        .out_IDEX_valid(out_IDEX_valid), .out_IDEX_pc(out_IDEX_pc), .out_IDEX_instr(out_IDEX_instr),
        .out_IDEX_rs_idx(out_IDEX_rs_idx), .out_IDEX_rt_idx(out_IDEX_rt_idx),
        .out_IDEX_rs_data(out_IDEX_rs_data), .out_IDEX_rt_data(out_IDEX_rt_data),
        .out_stall_cnt(out_stall_cnt)
    );

    always #5 in_clk = ~in_clk;

    // Behavioural model of the ID/EX contents and the stall counter.
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_rs_data, m_rt_data;
    logic [4:0]  m_rs_idx, m_rt_idx;
    int unsigned m_cnt;

    function automatic void model_reset();
        m_valid = 0; m_pc = 0; m_instr = 0; m_rs_idx = 0; m_rt_idx = 0;
        m_rs_data = 0; m_rt_data = 0; m_cnt = 0;
    endfunction

    // Advance the model by one edge using the inputs currently applied.
    function automatic void model_step();
        logic [31:0] ins;
        if (in_stall && m_valid && !in_flush && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (in_flush) begin
            m_valid = 0;
            m_instr = 0;
        end else if (in_stall) begin
            if (m_valid && in_MEMWB_RegWr && in_MEMWB_rd_idx != 0) begin
                if (in_MEMWB_rd_idx == m_rs_idx) m_rs_data = in_MEMWB_wdata;
                if (in_MEMWB_rd_idx == m_rt_idx) m_rt_data = in_MEMWB_wdata;
            end
        end else begin
            ins       = in_IFID_instr;
            m_valid   = in_IFID_valid;
            m_pc      = in_IFID_pc;
            m_instr   = ins;
            m_rs_idx  = ins[25:21];
            m_rt_idx  = ins[20:16];
            m_rs_data = in_Mem_forwardA ? in_MEMWB_wdata : in_rf_rs_data;
            m_rt_data = in_Mem_forwardB ? in_MEMWB_wdata : in_rf_rt_data;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_IFID_valid = 0; in_IFID_pc = 0; in_IFID_instr = 0;
        in_rf_rs_data = 0; in_rf_rt_data = 0;
        in_Mem_forwardA = 0; in_Mem_forwardB = 0;
        in_MEMWB_RegWr = 0; in_MEMWB_rd_idx = 0; in_MEMWB_wdata = 0;
        in_stall = 0; in_flush = 0;
    endtask

    task automatic test_reset();
        in_rst_n = 0;
        idle_inputs();
        model_reset();
        #12;
        checks++; if (out_IDEX_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", out_IDEX_valid); end
        checks++; if (out_IDEX_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_IDEX_pc); end
        checks++; if (out_IDEX_rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs_data got %h want 0", out_IDEX_rs_data); end
        checks++; if (out_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", out_stall_cnt); end
        @(negedge in_clk);
        in_rst_n = 1;
        @(posedge in_clk);
        #1;
    endtask

    task automatic test_plain_advance();
        in_IFID_valid = 1; in_IFID_pc = 32'h100; in_IFID_instr = 32'h012A4020;
        in_rf_rs_data = 32'h11; in_rf_rt_data = 32'h22;
        #1;
        checks++; if (out_IFID_rs_idx !== 5'd9) begin errors++; $display("FAIL ifid_rs_idx got %0d want 9", out_IFID_rs_idx); end
        checks++; if (out_IFID_rt_idx !== 5'd10) begin errors++; $display("FAIL ifid_rt_idx got %0d want 10", out_IFID_rt_idx); end
        tick();
        checks++; if (out_IDEX_valid !== 1'b1) begin errors++; $display("FAIL adv_valid got %h want 1", out_IDEX_valid); end
        checks++; if (out_IDEX_rs_data !== 32'h11) begin errors++; $display("FAIL adv_rs_data got %h want 11", out_IDEX_rs_data); end
        checks++; if (out_IDEX_rt_data !== 32'h22) begin errors++; $display("FAIL adv_rt_data got %h want 22", out_IDEX_rt_data); end
        checks++; if (out_IDEX_rs_idx !== 5'd9) begin errors++; $display("FAIL adv_rs_idx got %0d want 9", out_IDEX_rs_idx); end
        checks++; if (out_IDEX_pc !== 32'h100) begin errors++; $display("FAIL adv_pc got %h want 100", out_IDEX_pc); end
    endtask

    task automatic test_forward();
        in_IFID_pc = 32'h104; in_Mem_forwardA = 1; in_MEMWB_wdata = 32'hDEAD;
        in_rf_rs_data = 32'h11; in_rf_rt_data = 32'h22;
        tick();
        in_Mem_forwardA = 0;
        checks++; if (out_IDEX_rs_data !== 32'hDEAD) begin errors++; $display("FAIL fwd_rs_data got %h want dead", out_IDEX_rs_data); end
        checks++; if (out_IDEX_rt_data !== 32'h22) begin errors++; $display("FAIL fwd_rt_data got %h want 22", out_IDEX_rt_data); end
    endtask

    task automatic test_stall_snoop();
        // ID/EX holds rs=9 from the previous test; new IF/ID content must wait.
        in_IFID_pc = 32'h108; in_IFID_instr = 32'h016C5020;
        in_stall = 1;
        for (int c = 1; c <= 3; c++) begin
            in_MEMWB_RegWr  = (c == 2);
            in_MEMWB_rd_idx = 5'd9;
            in_MEMWB_wdata  = 32'hBEEF;
            tick();
        end
        in_MEMWB_RegWr = 0;
        checks++; if (out_IDEX_rs_data !== 32'hBEEF) begin errors++; $display("FAIL snoop_rs_data got %h want beef", out_IDEX_rs_data); end
        checks++; if (out_IDEX_rt_data !== 32'h22) begin errors++; $display("FAIL snoop_rt_data got %h want 22", out_IDEX_rt_data); end
        checks++; if (out_IDEX_pc !== 32'h104) begin errors++; $display("FAIL stall_pc_held got %h want 104", out_IDEX_pc); end
        checks++; if (out_stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", out_stall_cnt); end
        in_stall = 0;
        tick();
        checks++; if (out_IDEX_pc !== 32'h108) begin errors++; $display("FAIL stall_release_pc got %h want 108", out_IDEX_pc); end
        checks++; if (out_IDEX_rs_idx !== 5'd11) begin errors++; $display("FAIL stall_release_rs_idx got %0d want 11", out_IDEX_rs_idx); end
    endtask

    task automatic test_snoop_zero();
        in_IFID_pc = 32'h10C; in_IFID_instr = 32'h000A0000;
        in_rf_rs_data = 32'h55;
        tick();
        in_stall = 1; in_MEMWB_RegWr = 1; in_MEMWB_rd_idx = 5'd0; in_MEMWB_wdata = 32'hFFFF;
        tick();
        in_stall = 0; in_MEMWB_RegWr = 0;
        checks++; if (out_IDEX_rs_data !== 32'h55) begin errors++; $display("FAIL snoop_zero_rs_data got %h want 55", out_IDEX_rs_data); end
    endtask

    task automatic test_flush_stall();
        logic [15:0] cnt_before;
        cnt_before = out_stall_cnt;
        in_stall = 1; in_flush = 1;
        tick();
        in_stall = 0; in_flush = 0;
        checks++; if (out_IDEX_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %h want 0", out_IDEX_valid); end
        checks++; if (out_IDEX_instr !== 32'h0) begin errors++; $display("FAIL flush_instr got %h want 0", out_IDEX_instr); end
        checks++; if (out_stall_cnt !== cnt_before) begin errors++; $display("FAIL flush_cnt got %0d want %0d", out_stall_cnt, cnt_before); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_IFID_valid   = ($urandom_range(0, 3) != 0);
            in_IFID_pc      = $urandom;
            in_IFID_instr   = $urandom;
            in_rf_rs_data   = $urandom;
            in_rf_rt_data   = $urandom;
            in_Mem_forwardA = ($urandom_range(0, 3) == 0) && (in_IFID_instr[25:21] != 0);
            in_Mem_forwardB = ($urandom_range(0, 3) == 0) && (in_IFID_instr[20:16] != 0);
            in_MEMWB_RegWr  = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       in_MEMWB_rd_idx = m_rs_idx;
                1:       in_MEMWB_rd_idx = m_rt_idx;
                2:       in_MEMWB_rd_idx = 5'd0;
                default: in_MEMWB_rd_idx = 5'($urandom);
            endcase
            in_MEMWB_wdata  = $urandom;
            in_stall        = ($urandom_range(0, 9) < 4);
            in_flush        = ($urandom_range(0, 9) == 0);
            tick();
            checks++; if (out_IDEX_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %h want %h", n, out_IDEX_valid, m_valid); end
            checks++; if (out_IDEX_pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", n, out_IDEX_pc, m_pc); end
            checks++; if (out_IDEX_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", n, out_IDEX_instr, m_instr); end
            checks++; if (out_IDEX_rs_idx !== m_rs_idx) begin errors++; $display("FAIL rnd_rs_idx[%0d] got %h want %h", n, out_IDEX_rs_idx, m_rs_idx); end
            checks++; if (out_IDEX_rt_idx !== m_rt_idx) begin errors++; $display("FAIL rnd_rt_idx[%0d] got %h want %h", n, out_IDEX_rt_idx, m_rt_idx); end
            checks++; if (out_IDEX_rs_data !== m_rs_data) begin errors++; $display("FAIL rnd_rs_data[%0d] got %h want %h", n, out_IDEX_rs_data, m_rs_data); end
            checks++; if (out_IDEX_rt_data !== m_rt_data) begin errors++; $display("FAIL rnd_rt_data[%0d] got %h want %h", n, out_IDEX_rt_data, m_rt_data); end
            checks++; if (out_stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, out_stall_cnt, m_cnt); end
        end
        in_stall = 0; in_flush = 0; in_MEMWB_RegWr = 0;
        in_Mem_forwardA = 0; in_Mem_forwardB = 0;
    endtask

    task automatic test_reset_mid_stall();
        in_IFID_valid = 1; in_IFID_pc = 32'h200; in_IFID_instr = 32'h012A4020;
        in_rf_rs_data = 32'h77; in_rf_rt_data = 32'h88;
        tick();
        in_stall = 1;
        tick();
        tick();
        in_rst_n = 0;
        model_reset();
        #1;
        checks++; if (out_IDEX_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %h want 0", out_IDEX_valid); end
        checks++; if (out_IDEX_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_pc got %h want 0", out_IDEX_pc); end
        checks++; if (out_IDEX_instr !== 32'h0) begin errors++; $display("FAIL rst_mid_instr got %h want 0", out_IDEX_instr); end
        checks++; if (out_IDEX_rs_data !== 32'h0) begin errors++; $display("FAIL rst_mid_rs_data got %h want 0", out_IDEX_rs_data); end
        checks++; if (out_IDEX_rt_data !== 32'h0) begin errors++; $display("FAIL rst_mid_rt_data got %h want 0", out_IDEX_rt_data); end
        checks++; if (out_stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", out_stall_cnt); end
        @(negedge in_clk);
        in_rst_n = 1;
        in_stall = 0;
        in_IFID_pc = 32'h204;
        tick();
        checks++; if (out_IDEX_pc !== 32'h204) begin errors++; $display("FAIL rst_release_pc got %h want 204", out_IDEX_pc); end
        checks++; if (out_IDEX_rs_data !== 32'h77) begin errors++; $display("FAIL rst_release_rs_data got %h want 77", out_IDEX_rs_data); end
        checks++; if (out_IDEX_valid !== 1'b1) begin errors++; $display("FAIL rst_release_valid got %h want 1", out_IDEX_valid); end
    endtask

    initial begin
        test_reset();
        test_plain_advance();
        test_forward();
        test_stall_snoop();
        test_snoop_zero();
        test_flush_stall();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
